// File: rtl/keypad_matrix_scanner.sv
// Purpose : scans the 4x3 board keypad one row at a time and samples its
//           columns. Each full scan is debounced and multi-key presses are
//           rejected. The result is a level-type, one-hot key bus.
// Ports   : clk       - system clock, the only clock
//           rst       - synchronous, active-high reset
//           col_n     - matrix columns, active-low, asynchronous (pulled up)
//           row_n     - matrix row drive, active-low, one bit low at a time
//           key_level - one-hot digits 0-9 (bit n = digit n held)
//           sharp     - '#' held
//           star      - '*' held
//           key_valid - exactly one key held (OR of the key outputs)
module keypad_matrix_scanner #(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DEB_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [9:0] key_level,
  output logic       sharp,
  output logic       star,
  output logic       key_valid
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEB_FRAMES + 1);
  localparam int unsigned KEY_W = 12;

  // Column synchronizer
  logic [2:0]       col_meta_q, col_sync_q;
  logic [2:0]       col_act;

  // Scan timing
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       row_n_q, row_n_d;

  // Frame assembly and debounce
  logic [KEY_W-1:0] raw_q, raw_d;
  logic [KEY_W-1:0] prev_frame_q, prev_frame_d;
  logic [CNT_W-1:0] stable_q, stable_d;
  logic             commit_q, commit_d;
  logic             slot_end;

  // Outputs
  logic [9:0]       key_level_q, key_level_d;
  logic             sharp_q, sharp_d;
  logic             star_q, star_d;
  logic             valid_q, valid_d;

  assign col_act = ~col_sync_q;
  assign slot_end = (div_q == DIV_W'(SCAN_DIV - 1));

  // Row divider, frame assembly and debounce counter
  always_comb begin
    div_d        = div_q + DIV_W'(1);
    row_d        = row_q;
    raw_d        = raw_q;
    prev_frame_d = prev_frame_q;
    stable_d     = stable_q;
    commit_d     = 1'b0;

    if (slot_end) begin
      div_d = '0;
      row_d = row_q + 2'd1;
      case (row_q)
        2'd0:    raw_d[2:0]  = col_act;
        2'd1:    raw_d[5:3]  = col_act;
        2'd2:    raw_d[8:6]  = col_act;
        default: raw_d[11:9] = col_act;
      endcase

      // Row 3 sample completes the frame; raw_d now holds the whole scan.
      if (row_q == 2'd3) begin
        if (raw_d == prev_frame_q) begin
          if (stable_q != CNT_W'(DEB_FRAMES)) begin
            stable_d = stable_q + CNT_W'(1);
          end
          // Commit only on the frame that first reaches the threshold.
          commit_d = (stable_q == CNT_W'(DEB_FRAMES - 1));
        end else begin
          stable_d     = CNT_W'(1);
          prev_frame_d = raw_d;
          commit_d     = (DEB_FRAMES == 32'd1);
        end
      end
    end
  end

  assign row_n_d = ~(4'b0001 << row_d);

  // Key decode of the committed frame; anything but exactly one key clears all
  always_comb begin
    key_level_d = '0;
    sharp_d     = 1'b0;
    star_d      = 1'b0;
    valid_d     = 1'b0;
    if ($countones(prev_frame_q) == 1) begin
      key_level_d = {prev_frame_q[8:0], prev_frame_q[10]};
      star_d      = prev_frame_q[9];
      sharp_d     = prev_frame_q[11];
      valid_d     = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_q   <= '0;
      col_sync_q   <= '0;
      div_q        <= '0;
      row_q        <= '0;
      row_n_q      <= 4'b1110;
      raw_q        <= '0;
      prev_frame_q <= '0;
      stable_q     <= '0;
      commit_q     <= 1'b0;
      key_level_q  <= '0;
      sharp_q      <= 1'b0;
      star_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      col_meta_q   <= col_n;
      col_sync_q   <= col_meta_q;
      div_q        <= div_d;
      row_q        <= row_d;
      row_n_q      <= row_n_d;
      raw_q        <= raw_d;
      prev_frame_q <= prev_frame_d;
      stable_q     <= stable_d;
      commit_q     <= commit_d;
      if (commit_q) begin
        key_level_q <= key_level_d;
        sharp_q     <= sharp_d;
        star_q      <= star_d;
        valid_q     <= valid_d;
      end
    end
  end

  assign row_n     = row_n_q;
  assign key_level = key_level_q;
  assign sharp     = sharp_q;
  assign star      = star_q;
  assign key_valid = valid_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner with SCAN_DIV=8, DEB_FRAMES=2. A keypad
// matrix model pulls a column low when a pressed key sits on the driven row.
module tb_keypad_matrix_scanner;

  localparam int unsigned SD  = 8;
  localparam int unsigned DEB = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  col_n;
  logic [3:0]  row_n;
  logic [9:0]  key_level;
  logic        sharp, star, key_valid;
  logic [11:0] keys = '0;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  keypad_matrix_scanner #(.SCAN_DIV(SD), .DEB_FRAMES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_level (key_level),
    .sharp     (sharp),
    .star      (star),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  // Physical matrix: key (r,c) shorts row r to column c
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (row_n[r] == 1'b0 && keys[r*3+c]) col_n[c] = 1'b0;
  end

  // Reference model: cycle-indexed view of the scan
  int          j;
  logic [11:0] kh [4];
  logic [11:0] acc, last_fr, pend_fr;
  int          run_len;
  bit          pend;
  logic [3:0]  m_row_n;
  logic [9:0]  m_kl;
  logic        m_sharp, m_star, m_valid;

  task automatic m_apply(input logic [11:0] f);
    m_kl = '0; m_sharp = 1'b0; m_star = 1'b0; m_valid = 1'b0;
    if ($countones(f) == 1) begin
      m_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
        if (f[i]) begin
          if (i == 9)       m_star  = 1'b1;
          else if (i == 11) m_sharp = 1'b1;
          else if (i == 10) m_kl[0] = 1'b1;
          else              m_kl[i+1] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        j = 0; run_len = 0; pend = 1'b0; acc = '0; last_fr = '0;
        m_apply(12'h000);
        m_row_n = 4'b1110;
      end else begin
        j = j + 1;
        kh[j % 4] = keys;
        if (pend) begin
          m_apply(pend_fr);
          pend = 1'b0;
        end
        if (j % SD == 0) begin
          // sample reflects the keys two edges back, on the row that just ended
          for (int c = 0; c < 3; c++)
            acc[(((j-1)/SD) % 4)*3 + c] = kh[(j-2) % 4][(((j-1)/SD) % 4)*3 + c];
          if (j % (4*SD) == 0) begin
            if (run_len > 0 && acc == last_fr) run_len++;
            else begin
              run_len = 1;
              last_fr = acc;
            end
            if (run_len == DEB) begin
              pend    = 1'b1;
              pend_fr = acc;
            end
          end
        end
        m_row_n = ~(4'b0001 << ((j / SD) % 4));
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // One clock step; outputs are compared with the model away from the edge
  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      vectors++;
      if ({row_n, key_level, sharp, star, key_valid} !==
          {m_row_n, m_kl, m_sharp, m_star, m_valid}) begin
        miscompares++;
        $display("FAIL cycle_cmp at %0t: got row_n=%b key=%h sh=%b st=%b v=%b expected row_n=%b key=%h sh=%b st=%b v=%b",
                 $time, row_n, key_level, sharp, star, key_valid,
                 m_row_n, m_kl, m_sharp, m_star, m_valid);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input logic lvl, input int max_cyc, input string name);
    int cyc;
    cyc = 0;
    while (key_valid !== lvl && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    vectors++;
    if (key_valid !== lvl) begin
      miscompares++;
      $display("FAIL %s: key_valid=%b after %0d cycles, required %b", name, key_valid, cyc, lvl);
    end
  endtask

  initial begin
    int gap, seen, hold, kind, b0, b1;

    // 1: reset, idle scan
    @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    do_reset();
    check("row_after_reset", 16'(row_n), 16'h000e);
    repeat (8) tick();
    check("row_after_8", 16'(row_n), 16'h000d);
    repeat (192) tick();
    check("idle_outputs", 16'({key_level, sharp, star, key_valid}), 16'h0000);

    // 2: key '5'
    keys = 12'h010;
    wait_valid(1'b1, 99, "press5_latency");
    check("key5_level", 16'(key_level), 16'h0020);
    keys = '0;
    wait_valid(1'b0, 99, "release5_latency");
    check("key5_released", 16'(key_level), 16'h0000);

    // 3: '#' then swap to '*' with no gap
    keys = 12'h800;
    wait_valid(1'b1, 99, "press_sharp");
    check("sharp_only", 16'({sharp, star, key_level}), 16'h0800);
    keys = 12'h200;
    gap = 0;
    for (int c = 0; c < 99 && star !== 1'b1; c++) begin
      tick();
      if (sharp === star) gap++;
    end
    check("swap_star", 16'(star), 16'h0001);
    check("swap_sharp_low", 16'(sharp), 16'h0000);
    check("swap_no_gap", 16'(gap), 16'h0000);
    keys = '0;
    wait_valid(1'b0, 99, "release_star");

    // 4: '1' and '9' together are rejected
    keys = 12'h101;
    seen = 0;
    repeat (150) begin
      tick();
      if (key_valid !== 1'b0 || key_level !== 10'h000) seen++;
    end
    check("ghost_seen", 16'(seen), 16'h0000);
    keys = 12'h001;
    wait_valid(1'b1, 99, "press1_after_ghost");
    check("key1_level", 16'(key_level), 16'h0002);
    keys = '0;
    wait_valid(1'b0, 99, "release1");

    // 5: bouncing '0', then held
    for (int i = 0; i < 15; i++) begin
      keys[10] = ~keys[10];
      repeat (20) tick();
    end
    keys = 12'h400;
    repeat (3*32+3) tick();
    check("key0_level", 16'(key_level), 16'h0001);
    keys = '0;
    wait_valid(1'b0, 99, "release0");

    // 6: reset while '7' is committed
    keys = 12'h040;
    wait_valid(1'b1, 99, "press7");
    check("key7_level", 16'(key_level), 16'h0080);
    do_reset();
    check("reset_row", 16'(row_n), 16'h000e);
    check("reset_outputs", 16'({key_level, sharp, star, key_valid}), 16'h0000);
    wait_valid(1'b1, 99, "press7_after_reset");
    check("key7_again", 16'(key_level), 16'h0080);
    keys = '0;
    wait_valid(1'b0, 99, "release7");

    // Randomized phase: single, multi, bouncing presses and occasional resets
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) == 0) do_reset();
      kind = int'($urandom_range(0, 3));
      hold = int'($urandom_range(20, 160));
      b0   = int'($urandom_range(0, 11));
      b1   = int'($urandom_range(0, 11));
      case (kind)
        0: keys = '0;
        1: keys = 12'(1) << b0;
        2: keys = (12'(1) << b0) | (12'(1) << b1);
        default: begin
          for (int t = 0; t < 8; t++) begin
            keys[b0] = ~keys[b0];
            repeat ($urandom_range(1, 30)) tick();
          end
        end
      endcase
      repeat (hold) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
